// File: rtl/uart_fifo_tx.sv
// UART 8N1/8N2 transmitter that drains a byte FIFO: pops an entry, captures the
// FIFO's registered read data a cycle later and shifts it out LSB first on txd.
module uart_fifo_tx #(
   parameter int DATA_WID     = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_WID      = 10,
   parameter int STOP_BITS    = 1
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                tx_en,
   input  logic                fifo_empty,
   input  logic [DATA_WID-1:0] fifo_data,
   output logic                fifo_pop,
   output logic                txd,
   output logic                busy,
   output logic                tx_done
);

   localparam int BIT_WID = $clog2(DATA_WID + 1);

   localparam logic [CNT_WID-1:0] BAUD_LAST = CNT_WID'(CLKS_PER_BIT - 1);
   localparam logic [CNT_WID-1:0] BAUD_PEN  = CNT_WID'(CLKS_PER_BIT - 2);
   localparam logic [BIT_WID-1:0] LAST_BIT  = BIT_WID'(DATA_WID - 1);
   localparam logic [BIT_WID-1:0] LAST_STOP = BIT_WID'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   state_t              state;
   logic [CNT_WID-1:0]  baud_cnt;
   logic [BIT_WID-1:0]  bit_cnt;
   logic [DATA_WID-1:0] shreg;
   logic [DATA_WID-1:0] shreg_nxt;
   logic                bit_end;

   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign shreg_nxt = shreg >> 1;

   // Every output is a register updated on the transition into the state that
   // owns it, so nothing on the output side depends combinationally on inputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         fifo_pop <= 1'b0;
         txd      <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         fifo_pop <= 1'b0;
         tx_done  <= 1'b0;
         case (state)
            IDLE: begin
               txd  <= 1'b1;
               busy <= 1'b0;
               if (tx_en && !fifo_empty) begin
                  state    <= POP;
                  fifo_pop <= 1'b1;
                  busy     <= 1'b1;
               end
            end

            // fifo_data becomes valid during LOAD; fifo_empty is ignored here.
            POP: begin
               state <= LOAD;
            end

            LOAD: begin
               shreg    <= fifo_data;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               txd      <= 1'b0;
               state    <= START;
            end

            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  txd      <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shreg    <= shreg_nxt;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     txd     <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     txd     <= shreg_nxt[0];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            // bit_cnt counts stop bits here; tx_done is armed one cycle early
            // so the registered pulse lands in the final stop cycle.
            STOP: begin
               txd <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
                  if ((baud_cnt == BAUD_PEN) && (bit_cnt == LAST_STOP)) begin
                     tx_done <= 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

UART transmitter that drains a byte FIFO and serialises each entry onto a single TX line as 8N1 (or 8N2) frames. It sits on the read side of the TX-path FIFO in the UART/Wishbone bridge: it asserts pop when the FIFO is non-empty, captures the FIFO's registered read data one cycle later, and shifts it out LSB first. Baud timing comes from a parameterised clocks-per-bit divider; there is no oversampling.

## Interface
- DATA_WID, 8, data bits per frame; must equal the FIFO data width
- CLKS_PER_BIT, 868, clk cycles per serial bit; minimum 2
- CNT_WID, 10, baud counter width; must satisfy 2^CNT_WID > CLKS_PER_BIT-1
- STOP_BITS, 1, number of stop bits; legal values are 1 and 2

- clk  input  1  system clock; all state changes on the rising edge
- nrst  input  1  reset, asynchronous and active-low
- tx_en  input  1  transmit enable; gates only the start of new frames
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  DATA_WID  FIFO read data; valid in the cycle after fifo_pop is high
- fifo_pop  output  1  FIFO pop request; one-cycle pulse per byte
- txd  output  1  serial output, idle high
- busy  output  1  high in every state except IDLE
- tx_done  output  1  one-cycle pulse in the final clk cycle of the last stop bit

## Operation
- The FSM states are IDLE, POP, LOAD, START, DATA and STOP.
- **IDLE**
  - txd=1.
  - If tx_en=1 and fifo_empty=0, go to POP. Otherwise stay in IDLE.
- **POP**
  - fifo_pop=1 for exactly this cycle.
  - fifo_empty is not sampled in this state.
  - Always go to LOAD.
- **LOAD**
  - Load the shift register from fifo_data.
  - Clear the baud counter and the bit counter.
  - Go to START.
- **START**
  - txd=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA**
  - txd = shreg[0].
  - Every CLKS_PER_BIT cycles, shift right and increment the bit counter.
  - After DATA_WID bits, go to STOP.
- **STOP**
  - txd=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - tx_done=1 in the final cycle.
  - Then go to IDLE.
- **Baud counter**
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at the bit boundary.
  - It is CNT_WID bits wide, with no overflow beyond CLKS_PER_BIT-1.
- **Bit counter**
  - $clog2(DATA_WID+1) bits wide.
  - Reused for stop-bit counting when STOP_BITS=2.
- **Outputs**
  - txd, fifo_pop, busy and tx_done are registered: they are driven from state and registers, with no combinational path from any input.
- **tx_en**
  - Sampled only in IDLE.
  - Deasserting it mid-frame has no effect on the current frame.
- **Reset**
  - Reset values: state=IDLE, txd=1, fifo_pop=0, busy=0, tx_done=0, shift register=0, counters=0.
  - Reset asserted mid-frame forces txd high immediately (asynchronously) and abandons the frame.
  - The byte already popped is discarded and tx_done is not pulsed.
- The block never pops while fifo_empty=1, because the empty check happens in IDLE only.

## Timing
- fifo_empty falls in cycle N (state IDLE):
  - fifo_pop is high in cycle N+1.
  - fifo_data is captured in cycle N+2.
  - The start bit begins in cycle N+3.
- Frame length is (1+DATA_WID+STOP_BITS)×CLKS_PER_BIT cycles of txd activity.
- busy is high from cycle N+1 through the last stop-bit cycle.
- Back-to-back bytes: after the last stop cycle, IDLE, POP and LOAD take 3 cycles with txd=1, then the next start bit begins.
  - The inter-frame gap is therefore exactly 3 cycles beyond the stop bits.
- Exactly one fifo_pop pulse occurs per transmitted frame.

## Test plan
- **Reset values:** drive nrst=0 mid-run → txd=1, fifo_pop=0, busy=0 and tx_done=0 within the same cycle, without waiting for a clk edge.
- **Single byte:** CLKS_PER_BIT=4, single byte 0xA5, fifo_empty falls in cycle 0. Required:
  - fifo_pop high in cycle 1 only.
  - txd=0 in cycles 3–6.
  - Data bits 1,0,1,0,0,1,0,1 for 4 cycles each, in cycles 7–38.
  - txd=1 in cycles 39–42.
  - tx_done=1 in cycle 42 only; busy=0 from cycle 43.
- **Back-to-back:** bytes 0x00 then 0xFF queued → second start bit exactly 4 cycles after the first frame's last stop cycle. Two pops total, and txd never glitches low between frames.
- **tx_en gating:** hold tx_en=0 with fifo_empty=0 for 20 cycles → no pop and txd=1 throughout. Then raise tx_en, start a frame, and drop tx_en in DATA → the full 40-cycle frame still completes and no further pop follows.
- **Reset mid-frame:** assert nrst=0 during data bit 3 → txd=1 immediately, no tx_done. After release with fifo_empty=0 → the next pop occurs 1 cycle after the first clk edge following release.
- **Two stop bits:** STOP_BITS=2, CLKS_PER_BIT=4, byte 0x3C → stop high for 8 cycles, 44-cycle frame, and tx_done in the 44th cycle.
